// File: rtl/uart_cmd_framer.sv
// ---------------------------------------------------------------------------
// uart_cmd_framer
//
// Sits between the byte-level UART and the command processor.
//
// RX path: collects CMD_BYTES received bytes into one command word (first
// byte received lands in the MSBs). A completed frame is copied into the
// double-buffered cmd output together with cmd_rdy. A frame that completes
// while the previous one is still unacknowledged sets the sticky overrun
// flag. A partial frame left idle for TIMEOUT_CYC clocks is discarded with
// a one-cycle frame_err pulse. TIMEOUT_CYC = 0 disables the timeout.
//
// TX path: latches a RESP_BYTES response word and feeds it to the UART one
// byte at a time (MSB byte first) using the trmt / tx_done handshake.
//
// The RX and TX paths share only the clock and reset.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   rx_rdy       UART received byte valid (level, held until cleared)
//   rx_data      UART received byte
//   clr_rx_rdy   one-cycle acknowledge of rx_data
//   cmd          last complete command, first byte in the MSBs
//   cmd_rdy      complete command available
//   clr_cmd_rdy  consumer acknowledge of cmd
//   overrun      sticky: a frame completed while cmd_rdy was still set
//   frame_err    one-cycle pulse: partial frame dropped on timeout
//   resp_vld     response request
//   resp_data    response word, MSB byte sent first
//   resp_busy    response transmission in progress
//   trmt         one-cycle pulse starting a UART byte transmit
//   tx_data      byte being transmitted, stable from trmt until tx_done
//   tx_done      UART transmit complete (level)
// ---------------------------------------------------------------------------
module uart_cmd_framer #(
  parameter int CMD_BYTES   = 3,
  parameter int RESP_BYTES  = 1,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rx_rdy,
  input  logic [7:0]              rx_data,
  output logic                    clr_rx_rdy,
  output logic [8*CMD_BYTES-1:0]  cmd,
  output logic                    cmd_rdy,
  input  logic                    clr_cmd_rdy,
  output logic                    overrun,
  output logic                    frame_err,
  input  logic                    resp_vld,
  input  logic [8*RESP_BYTES-1:0] resp_data,
  output logic                    resp_busy,
  output logic                    trmt,
  output logic [7:0]              tx_data,
  input  logic                    tx_done
);

  localparam int IDX_W    = (CMD_BYTES > 1)   ? $clog2(CMD_BYTES)   : 1;
  localparam int K_W      = (RESP_BYTES > 1)  ? $clog2(RESP_BYTES)  : 1;
  localparam int CNT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int TMO_LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1     : 0;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CMD_BYTES - 1);
  localparam logic [K_W-1:0]   K_LAST   = K_W'(RESP_BYTES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TMO_LAST);

  typedef enum logic {
    RX_WAIT,
    RX_ACK
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SEND,
    TX_HOLD,
    TX_WAIT
  } tx_state_t;

  // ---------------------------------------------------------------------
  // RX path
  // ---------------------------------------------------------------------
  rx_state_t             rx_state;
  rx_state_t             rx_next;
  logic [IDX_W-1:0]      idx;
  logic [8*CMD_BYTES-1:0] asm_buf;
  logic [8*CMD_BYTES-1:0] asm_next;
  logic [CNT_W-1:0]      tmo_cnt;
  logic                  capture;
  logic                  frame_done;
  logic                  tmo_expire;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state <= RX_WAIT;
    end else begin
      rx_state <= rx_next;
    end
  end

  // RX_ACK swallows the cycle in which the UART is still dropping rx_rdy,
  // so a byte can never be captured twice.
  always_comb begin
    rx_next    = rx_state;
    clr_rx_rdy = 1'b0;
    capture    = 1'b0;
    case (rx_state)
      RX_WAIT: begin
        if (rx_rdy) begin
          clr_rx_rdy = 1'b1;
          capture    = 1'b1;
          rx_next    = RX_ACK;
        end
      end
      RX_ACK:  rx_next = RX_WAIT;
      default: rx_next = RX_WAIT;
    endcase
  end

  // asm_next is the assembly buffer with the byte being captured this cycle
  // merged in, so a completing frame can go straight into cmd at the same
  // edge. A capture in the expiry cycle keeps the frame alive.
  always_comb begin
    frame_done = capture && (idx == IDX_LAST);
    tmo_expire = (TIMEOUT_CYC != 0) && (idx != '0) && !capture &&
                 (tmo_cnt == CNT_LAST);
    asm_next   = asm_buf;
    for (int i = 0; i < CMD_BYTES; i++) begin
      if (capture && (idx == IDX_W'(i))) begin
        asm_next[8*(CMD_BYTES-1-i) +: 8] = rx_data;
      end
    end
  end

  // Frame completion has priority over clr_cmd_rdy, so a consumer ack that
  // coincides with a new frame never loses it and never flags an overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      asm_buf   <= '0;
      cmd       <= '0;
      cmd_rdy   <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      tmo_cnt   <= '0;
    end else begin
      frame_err <= tmo_expire;

      if (capture) begin
        asm_buf <= asm_next;
      end

      if (frame_done || tmo_expire) begin
        idx <= '0;
      end else if (capture) begin
        idx <= idx + IDX_W'(1);
      end

      if (capture || (idx == '0) || tmo_expire || (TIMEOUT_CYC == 0)) begin
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + CNT_W'(1);
      end

      if (frame_done) begin
        cmd     <= asm_next;
        cmd_rdy <= 1'b1;
      end else if (clr_cmd_rdy) begin
        cmd_rdy <= 1'b0;
      end

      if (frame_done && cmd_rdy && !clr_cmd_rdy) begin
        overrun <= 1'b1;
      end else if (clr_cmd_rdy) begin
        overrun <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------
  // TX path
  // ---------------------------------------------------------------------
  tx_state_t               tx_state;
  tx_state_t               tx_next;
  logic [8*RESP_BYTES-1:0] resp_buf;
  logic [K_W-1:0]          k;
  logic                    resp_latch;
  logic                    k_advance;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
    end else begin
      tx_state <= tx_next;
    end
  end

  // TX_HOLD covers the cycle where tx_done may still be high from the
  // previous byte before the UART has reacted to trmt.
  always_comb begin
    tx_next    = tx_state;
    trmt       = 1'b0;
    resp_latch = 1'b0;
    k_advance  = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (resp_vld) begin
          resp_latch = 1'b1;
          tx_next    = TX_SEND;
        end
      end
      TX_SEND: begin
        trmt    = 1'b1;
        tx_next = TX_HOLD;
      end
      TX_HOLD: tx_next = TX_WAIT;
      TX_WAIT: begin
        if (tx_done) begin
          if (k == K_LAST) begin
            tx_next = TX_IDLE;
          end else begin
            k_advance = 1'b1;
            tx_next   = TX_SEND;
          end
        end
      end
      default: tx_next = TX_IDLE;
    endcase
  end

  // tx_data is a pure select of the latched word, so it stays put until k
  // moves on after tx_done, and reads 0 after reset.
  always_comb begin
    resp_busy = (tx_state != TX_IDLE);
    tx_data   = 8'h00;
    for (int j = 0; j < RESP_BYTES; j++) begin
      if (k == K_W'(j)) begin
        tx_data = resp_buf[8*(RESP_BYTES-1-j) +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_buf <= '0;
      k        <= '0;
    end else if (resp_latch) begin
      resp_buf <= resp_data;
      k        <= '0;
    end else if (k_advance) begin
      k <= k + K_W'(1);
    end
  end

endmodule

// File: tb/tb_uart_cmd_framer.sv
// ---------------------------------------------------------------------------
// tb_uart_cmd_framer
//
// Directed bench for uart_cmd_framer with CMD_BYTES=3, RESP_BYTES=2,
// TIMEOUT_CYC=50. Expected command words and expected transmit bytes are
// queued when stimulus is driven and popped when the DUT produces them.
// A small UART transmitter model answers trmt with tx_done 10 clocks later.
// ---------------------------------------------------------------------------
module tb_uart_cmd_framer;

  localparam int CB = 3;
  localparam int RB = 2;
  localparam int TO = 50;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_rdy;
  logic [7:0]    rx_data;
  logic          clr_rx_rdy;
  logic [8*CB-1:0] cmd;
  logic          cmd_rdy;
  logic          clr_cmd_rdy;
  logic          overrun;
  logic          frame_err;
  logic          resp_vld;
  logic [8*RB-1:0] resp_data;
  logic          resp_busy;
  logic          trmt;
  logic [7:0]    tx_data;
  logic          tx_done;

  int            n_checks = 0;
  int            n_fails  = 0;
  int            cyc      = 0;
  int            trmt_count = 0;
  int            last_done_cyc = 0;
  logic          tx_abort = 1'b0;
  logic          rdy_after_cap;
  logic [8*CB-1:0] cmd_at_cap;

  logic [8*CB-1:0] exp_cmd_q[$];
  logic [7:0]      exp_tx_q[$];

  uart_cmd_framer #(
    .CMD_BYTES  (CB),
    .RESP_BYTES (RB),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_rdy     (rx_rdy),
    .rx_data    (rx_data),
    .clr_rx_rdy (clr_rx_rdy),
    .cmd        (cmd),
    .cmd_rdy    (cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy),
    .overrun    (overrun),
    .frame_err  (frame_err),
    .resp_vld   (resp_vld),
    .resp_data  (resp_data),
    .resp_busy  (resp_busy),
    .trmt       (trmt),
    .tx_data    (tx_data),
    .tx_done    (tx_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // One comparison: counts it, and on mismatch counts and reports a failure.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents one byte on rx_rdy/rx_data the way the UART does: held until
  // clr_rx_rdy, still high for one more cycle, then dropped.
  task automatic applyStimulus(input logic [7:0] b, input logic clr_on_cap);
    int   waited;
    logic seen;
    waited  = 0;
    seen    = 1'b0;
    rx_data = b;
    rx_rdy  = 1'b1;
    if (clr_on_cap) clr_cmd_rdy = 1'b1;
    while (!seen && waited < 10) begin
      @(negedge clk);
      if (clr_rx_rdy === 1'b1) begin
        seen       = 1'b1;
        cmd_at_cap = cmd;
      end
      @(posedge clk); #1;
      waited++;
    end
    checkOutput("clr_rx_rdy_seen", {31'd0, seen}, 32'd1);
    clr_cmd_rdy = 1'b0;
    @(negedge clk);
    checkOutput("no_double_ack", {31'd0, clr_rx_rdy}, 32'd0);
    rdy_after_cap = cmd_rdy;
    @(posedge clk); #1;
    rx_rdy = 1'b0;
  endtask

  task automatic sendFrame(input logic [8*CB-1:0] w, input logic clr_last);
    logic [8*CB-1:0] exp_w;
    exp_cmd_q.push_back(w);
    for (int i = 0; i < CB; i++) begin
      applyStimulus(w[8*(CB-1-i) +: 8], clr_last && (i == CB - 1));
    end
    exp_w = exp_cmd_q.pop_front();
    checkOutput("cmd_not_early", {8'd0, cmd_at_cap == exp_w ? 24'd1 : 24'd0}, 32'd0);
    checkOutput("cmd_rdy_latency", {31'd0, rdy_after_cap}, 32'd1);
    checkOutput("cmd_word", {8'd0, cmd}, {8'd0, exp_w});
  endtask

  // UART transmitter model: tx_done drops on trmt, rises 10 clocks later.
  initial begin
    logic [7:0] exp_b;
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (trmt === 1'b1) begin
        trmt_count++;
        tx_done = 1'b0;
        checkOutput("tx_byte_expected", {31'd0, exp_tx_q.size() != 0}, 32'd1);
        exp_b = (exp_tx_q.size() != 0) ? exp_tx_q.pop_front() : 8'h00;
        checkOutput("tx_data_at_trmt", {24'd0, tx_data}, {24'd0, exp_b});
        repeat (10) @(posedge clk);
        #1;
        tx_done       = 1'b1;
        last_done_cyc = cyc;
        if (!tx_abort) begin
          checkOutput("tx_data_stable", {24'd0, tx_data}, {24'd0, exp_b});
        end
      end
    end
  end

  initial begin
    int first_err;
    int err_pulses;
    int n;
    int fall_cyc;

    rst         = 1'b1;
    rx_rdy      = 1'b0;
    rx_data     = 8'h00;
    clr_cmd_rdy = 1'b0;
    resp_vld    = 1'b0;
    resp_data   = '0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    checkOutput("rst_cmd",       {8'd0, cmd}, 32'd0);
    checkOutput("rst_cmd_rdy",   {31'd0, cmd_rdy}, 32'd0);
    checkOutput("rst_overrun",   {31'd0, overrun}, 32'd0);
    checkOutput("rst_frame_err", {31'd0, frame_err}, 32'd0);
    checkOutput("rst_resp_busy", {31'd0, resp_busy}, 32'd0);
    checkOutput("rst_trmt",      {31'd0, trmt}, 32'd0);
    checkOutput("rst_tx_data",   {24'd0, tx_data}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic frame and consumer acknowledge
    $display("[TB] basic frame");
    sendFrame(24'hA53C0F, 1'b0);
    clr_cmd_rdy = 1'b1;
    @(posedge clk); #1;
    clr_cmd_rdy = 1'b0;
    checkOutput("ack_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
    checkOutput("ack_cmd_kept", {8'd0, cmd}, 32'h00A53C0F);

    // Partial frame timeout
    $display("[TB] inter-byte timeout");
    applyStimulus(8'h11, 1'b0);
    applyStimulus(8'h22, 1'b0);
    first_err  = 0;
    err_pulses = 0;
    if (frame_err) begin
      err_pulses++;
      first_err = 1;
    end
    for (int e = 2; e <= 60; e++) begin
      @(posedge clk); #1;
      if (frame_err) begin
        err_pulses++;
        if (first_err == 0) first_err = e;
      end
    end
    checkOutput("tmo_first_edge", first_err, 32'd50);
    checkOutput("tmo_pulse_count", err_pulses, 32'd1);
    checkOutput("tmo_cmd_kept", {8'd0, cmd}, 32'h00A53C0F);
    checkOutput("tmo_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
    sendFrame(24'h334455, 1'b0);
    clr_cmd_rdy = 1'b1;
    @(posedge clk); #1;
    clr_cmd_rdy = 1'b0;

    // Overrun
    $display("[TB] overrun");
    sendFrame(24'h010203, 1'b0);
    sendFrame(24'h040506, 1'b0);
    checkOutput("ovr_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);
    checkOutput("ovr_set", {31'd0, overrun}, 32'd1);
    clr_cmd_rdy = 1'b1;
    @(posedge clk); #1;
    clr_cmd_rdy = 1'b0;
    checkOutput("ovr_clr_rdy", {31'd0, cmd_rdy}, 32'd0);
    checkOutput("ovr_clr_flag", {31'd0, overrun}, 32'd0);

    // Ack coinciding with completion
    $display("[TB] ack on completion edge");
    sendFrame(24'h070809, 1'b0);
    sendFrame(24'h0A0B0C, 1'b1);
    checkOutput("coinc_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);
    checkOutput("coinc_overrun", {31'd0, overrun}, 32'd0);

    // Response transmit
    $display("[TB] response BEEF");
    resp_data = 16'hBEEF;
    resp_vld  = 1'b1;
    exp_tx_q.push_back(8'hBE);
    exp_tx_q.push_back(8'hEF);
    @(posedge clk); #1;
    resp_vld  = 1'b0;
    resp_data = 16'h1234;
    checkOutput("tx_busy_set", {31'd0, resp_busy}, 32'd1);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("tx_busy_mid", {31'd0, resp_busy}, 32'd1);
    resp_vld = 1'b1;
    @(posedge clk); #1;
    resp_vld = 1'b0;
    n = 0;
    while (resp_busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    fall_cyc = cyc;
    checkOutput("tx_busy_fell", {31'd0, resp_busy}, 32'd0);
    checkOutput("tx_busy_fall_time", fall_cyc, last_done_cyc + 1);
    repeat (20) @(posedge clk);
    #1;
    checkOutput("tx_two_bytes", trmt_count, 32'd2);

    // Reset mid-frame and during a transmit
    $display("[TB] reset mid-activity");
    applyStimulus(8'h21, 1'b0);
    applyStimulus(8'h22, 1'b0);
    resp_data = 16'hCAFE;
    resp_vld  = 1'b1;
    exp_tx_q.push_back(8'hCA);
    @(posedge clk); #1;
    resp_vld = 1'b0;
    n = 0;
    while (trmt !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("rst_trmt_seen", {31'd0, trmt}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    tx_abort = 1'b1;
    rst      = 1'b1;
    @(posedge clk); #1;
    checkOutput("mid_rst_cmd",       {8'd0, cmd}, 32'd0);
    checkOutput("mid_rst_cmd_rdy",   {31'd0, cmd_rdy}, 32'd0);
    checkOutput("mid_rst_overrun",   {31'd0, overrun}, 32'd0);
    checkOutput("mid_rst_frame_err", {31'd0, frame_err}, 32'd0);
    checkOutput("mid_rst_clr_rx",    {31'd0, clr_rx_rdy}, 32'd0);
    checkOutput("mid_rst_busy",      {31'd0, resp_busy}, 32'd0);
    checkOutput("mid_rst_trmt",      {31'd0, trmt}, 32'd0);
    checkOutput("mid_rst_tx_data",   {24'd0, tx_data}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    sendFrame(24'h0D0E0F, 1'b0);
    checkOutput("post_rst_overrun", {31'd0, overrun}, 32'd0);

    repeat (30) @(posedge clk);
    #1;
    checkOutput("trmt_total", trmt_count, 32'd3);
    checkOutput("tx_queue_drained", exp_tx_q.size(), 32'd0);
    checkOutput("cmd_queue_drained", exp_cmd_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
